// File: rtl/dsp_mem_arbiter_if.sv
// dsp_mem_arbiter_if: core/loader request ports and the memory bank bus.
// slave = arbiter side, master = requesters plus memory model side.
interface dsp_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              a_req;
  logic              a_we;
  logic              a_lock;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic              b_lock;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_en;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  a_req, a_we, a_lock, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_lock, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_addr, mem_wdata, mem_we, mem_en,
    input  mem_rdata
  );

  modport master (
    output a_req, a_we, a_lock, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_lock, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_en,
    output mem_rdata
  );
endinterface

// File: rtl/dsp_mem_arbiter.sv
// dsp_mem_arbiter: two-port round-robin arbiter for Data Memory Bank II.
// Ports: clk, rst (async, active-high), bus (dsp_mem_arbiter_if.slave):
//   a_* core port, b_* sample-loader port, mem_* synchronous memory bus.
// Macro DSP_ARB_LOCK_EN enables the lock FSM (OWN_A/OWN_B, MAX_LOCK cap);
// without it a_lock/b_lock are ignored and arbitration is pure round-robin.
module dsp_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst,
  dsp_mem_arbiter_if.slave  bus
);

  // last_winner: 0 = A, 1 = B
  logic              last_winner;
  logic              a_gnt;
  logic              b_gnt;
  logic              a_acc;
  logic              b_acc;
  logic              own_a;
  logic              own_b;
  logic              a_rvalid;
  logic              b_rvalid;
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

`ifdef DSP_ARB_LOCK_EN
  typedef enum logic [1:0] {
    IDLE,
    OWN_A,
    OWN_B
  } state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

  state_t     state;
  logic [7:0] lock_cnt;

  assign own_a = (state == OWN_A);
  assign own_b = (state == OWN_B);

  // A lock of length one can never be held, so MAX_LOCK=1 stays in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lock_cnt <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (a_acc && bus.a_lock && MAX_CNT != 8'd1) begin
            state    <= OWN_A;
            lock_cnt <= 8'd1;
          end else if (b_acc && bus.b_lock && MAX_CNT != 8'd1) begin
            state    <= OWN_B;
            lock_cnt <= 8'd1;
          end
        end
        OWN_A: begin
          if (!bus.a_req) begin
            state    <= IDLE;
            lock_cnt <= 8'd0;
          end else if (!bus.a_lock || lock_cnt + 8'd1 == MAX_CNT) begin
            state    <= IDLE;
            lock_cnt <= 8'd0;
          end else begin
            lock_cnt <= lock_cnt + 8'd1;
          end
        end
        OWN_B: begin
          if (!bus.b_req) begin
            state    <= IDLE;
            lock_cnt <= 8'd0;
          end else if (!bus.b_lock || lock_cnt + 8'd1 == MAX_CNT) begin
            state    <= IDLE;
            lock_cnt <= 8'd0;
          end else begin
            lock_cnt <= lock_cnt + 8'd1;
          end
        end
        default: begin
          state    <= IDLE;
          lock_cnt <= 8'd0;
        end
      endcase
    end
  end
`else
  logic unused_lock;

  assign own_a       = 1'b0;
  assign own_b       = 1'b0;
  assign unused_lock = bus.a_lock ^ bus.b_lock;
`endif

  // Grants are gated by rst so nothing is granted while reset is held.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!rst) begin
      if (own_a) begin
        a_gnt = bus.a_req;
      end else if (own_b) begin
        b_gnt = bus.b_req;
      end else if (bus.a_req && bus.b_req) begin
        a_gnt = last_winner;
        b_gnt = !last_winner;
      end else begin
        a_gnt = bus.a_req;
        b_gnt = bus.b_req;
      end
    end
  end

  assign a_acc = bus.a_req & a_gnt;
  assign b_acc = bus.b_req & b_gnt;

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    if (a_gnt) begin
      bus.mem_addr  = bus.a_addr;
      bus.mem_wdata = bus.a_wdata;
      bus.mem_we    = bus.a_we;
    end else if (b_gnt) begin
      bus.mem_addr  = bus.b_addr;
      bus.mem_wdata = bus.b_wdata;
      bus.mem_we    = bus.b_we;
    end
  end

  assign bus.mem_en = a_gnt | b_gnt;
  assign bus.a_gnt  = a_gnt;
  assign bus.b_gnt  = b_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_winner <= 1'b1;
    end else if (a_acc) begin
      last_winner <= 1'b0;
    end else if (b_acc) begin
      last_winner <= 1'b1;
    end
  end

  // Memory data is valid in the rvalid cycle itself; the holding
  // register keeps it visible afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_rvalid <= a_acc & ~bus.a_we;
      b_rvalid <= b_acc & ~bus.b_we;
      if (a_rvalid) a_rdata_q <= bus.mem_rdata;
      if (b_rvalid) b_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.a_rvalid = a_rvalid;
  assign bus.b_rvalid = b_rvalid;
  assign bus.a_rdata  = a_rvalid ? bus.mem_rdata : a_rdata_q;
  assign bus.b_rdata  = b_rvalid ? bus.mem_rdata : b_rdata_q;

endmodule
